// File: rtl/imem_loader.sv
// imem_loader: boot/reload controller for the three-stage CPU.
// Holds the CPU in reset and takes a byte stream over valid/ready. The stream
// starts with a 16-bit little-endian word count, followed by that many
// little-endian 32-bit words. Each word is written to instruction memory,
// starting at word address 0. When the load finishes, the CPU is released.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   load_req            reload request (only honoured in RUN)
//   in_data/in_valid    byte stream in; in_ready is decoded from state only
//   imem_we/addr/wdata  instruction-memory write port (registered)
//   cpu_rst             CPU reset, high while loading (registered)
//   busy                high in any state but RUN (decoded)
//   load_err            sticky: header count exceeded memory depth
//   words_loaded        words actually written by the current/last load
module imem_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  // The depth is kept 17 bits wide so that 2^16 can be represented when ADDR_W=16.
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  typedef enum logic [2:0] {RUN, HDR0, HDR1, DATA, FLUSH} state_t;

  state_t      state, state_n;
  logic [7:0]  count_lo;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] wbuf;       // first three bytes of the word being assembled
  logic [15:0] word_nxt;
  logic [15:0] full_count;
  logic        xfer;

  assign xfer       = in_valid && in_ready;
  assign word_nxt   = word_idx + 16'd1;
  assign full_count = {in_data, count_lo};

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b1;
    unique case (state)
      RUN: begin
        busy = 1'b0;
        if (load_req) state_n = HDR0;
      end
      HDR0: begin
        in_ready = 1'b1;
        if (in_valid) state_n = HDR1;
      end
      HDR1: begin
        in_ready = 1'b1;
        if (in_valid) state_n = (full_count == 16'd0) ? FLUSH : DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid && byte_idx == 2'd3 && word_nxt == count) state_n = FLUSH;
      end
      FLUSH:   state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cpu_rst      <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      count_lo     <= '0;
      count        <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      wbuf         <= '0;
    end else begin
      state   <= state_n;
      // cpu_rst tracks the state we are entering, so it rises together with HDR0
      // and falls together with RUN.
      cpu_rst <= (state_n != RUN);
      imem_we <= 1'b0;
      unique case (state)
        RUN: if (load_req) begin
          word_idx     <= '0;
          byte_idx     <= '0;
          words_loaded <= '0;
          load_err     <= 1'b0;
        end
        HDR0: if (xfer) count_lo <= in_data;
        HDR1: if (xfer) begin
          count <= full_count;
          if ({1'b0, full_count} > DEPTH) load_err <= 1'b1;
        end
        DATA: if (xfer) begin
          unique case (byte_idx)
            2'd0: wbuf[7:0]   <= in_data;
            2'd1: wbuf[15:8]  <= in_data;
            2'd2: wbuf[23:16] <= in_data;
            default: begin
              // Words beyond the memory depth are consumed but dropped, with no address wrap.
              if ({1'b0, word_idx} < DEPTH) begin
                imem_we      <= 1'b1;
                imem_addr    <= word_idx[ADDR_W-1:0];
                imem_wdata   <= {in_data, wbuf};
                words_loaded <= words_loaded + 16'd1;
              end
              word_idx <= word_nxt;
            end
          endcase
          byte_idx <= byte_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. A 12-bit and a 2-bit address instance share one
// stimulus stream, and each instance has its own write scoreboard.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, load_req, in_valid;
  logic [7:0]  in_data;

  logic        rdy12, we12, cpu12, busy12, err12;
  logic [11:0] addr12;
  logic [31:0] wd12;
  logic [15:0] wl12;
  logic        rdy2, we2, cpu2, busy2, err2;
  logic [1:0]  addr2;
  logic [31:0] wd2;
  logic [15:0] wl2;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, wc_last = 0, wc_prev = 0;
  logic [47:0] q12[$], q2[$];
  logic [7:0]  stim[$];

  imem_loader #(.ADDR_W(12)) u12 (
    .clk(clk), .rst(rst), .load_req(load_req), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy12), .imem_we(we12), .imem_addr(addr12), .imem_wdata(wd12),
    .cpu_rst(cpu12), .busy(busy12), .load_err(err12), .words_loaded(wl12));

  imem_loader #(.ADDR_W(2)) u2 (
    .clk(clk), .rst(rst), .load_req(load_req), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy2), .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2),
    .cpu_rst(cpu2), .busy(busy2), .load_err(err2), .words_loaded(wl2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboards: entries are {addr[15:0], data[31:0]}.
  always @(negedge clk) begin
    logic [47:0] e;
    if (we12) begin
      chk("u12_wr_expected", 32'(q12.size() != 0), 32'd1);
      if (q12.size() != 0) begin
        e = q12.pop_front();
        chk("u12_addr", 32'(addr12), 32'(e[47:32]));
        chk("u12_data", wd12, e[31:0]);
      end
      wc_prev = wc_last;
      wc_last = cyc;
    end
  end

  always @(negedge clk) begin
    logic [47:0] e;
    if (we2) begin
      chk("u2_wr_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("u2_addr", 32'(addr2), 32'(e[47:32]));
        chk("u2_data", wd2, e[31:0]);
      end
    end
  end

  task automatic push_both(input logic [15:0] a, input logic [31:0] d);
    q12.push_back({a, d});
    q2.push_back({a, d});
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    chk("hdr0_cpu_rst", 32'(cpu12), 32'd1);
    chk("hdr0_busy", 32'(busy12), 32'd1);
    chk("hdr0_in_ready", 32'(rdy12), 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!rdy12 && n < 50) begin @(posedge clk); #1; n++; end
    chk("send_ready", 32'(rdy12), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Gap modes: 0 = back-to-back, 1 = valid every other cycle, 2 = random 0..5 idle cycles.
  task automatic run_stim(input int mode);
    for (int i = 0; i < stim.size(); i++) begin
      send(stim[i]);
      if (i != stim.size() - 1) begin
        if (mode == 1) idle(1);
        else if (mode == 2) idle(int'($urandom_range(0, 5)));
      end
    end
    stim.delete();
  endtask

  // The call happens at the cycle right after the last transfer (the FLUSH cycle).
  task automatic flush_chk(input string tag);
    chk({tag, "_flush_busy"}, 32'(busy12), 32'd1);
    chk({tag, "_flush_cpu_rst"}, 32'(cpu12), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_run_cpu_rst"}, 32'(cpu12), 32'd0);
    chk({tag, "_run_busy"}, 32'(busy12), 32'd0);
  endtask

  task automatic two_word_load(input int mode, input string tag);
    push_both(16'd0, 32'h0000_0013);
    push_both(16'd1, 32'h0000_12B7);
    start();
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h12, 8'h00, 8'h00};
    run_stim(mode);
    flush_chk(tag);
    chk({tag, "_words_loaded"}, 32'(wl12), 32'd2);
    chk({tag, "_load_err"}, 32'(err12), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_rst", 32'(cpu12), 32'd1);
    chk("rst_busy", 32'(busy12), 32'd0);
    chk("rst_in_ready", 32'(rdy12), 32'd0);
    chk("rst_we", 32'(we12), 32'd0);
    chk("rst_words", 32'(wl12), 32'd0);
    chk("rst_err", 32'(err12), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_cpu_rst_c1", 32'(cpu12), 32'd1);
    @(negedge clk);
    chk("rel_cpu_rst_c2", 32'(cpu12), 32'd0);
    chk("rel_busy", 32'(busy12), 32'd0);
    chk("rel_in_ready", 32'(rdy12), 32'd0);
    @(posedge clk); #1;

    // Back-to-back two-word program.
    two_word_load(0, "b2b");
    chk("b2b_wr_spacing", 32'(wc_last - wc_prev), 32'd4);
    idle(2);

    // The same program with throttled and gappy input.
    two_word_load(1, "toggle");
    idle(3);
    two_word_load(2, "gaps");
    idle(1);

    // Empty program.
    start();
    stim = '{8'h00, 8'h00};
    run_stim(0);
    flush_chk("empty");
    chk("empty_words", 32'(wl12), 32'd0);
    idle(2);

    // Five words: the 2-bit instance overflows after word 3.
    start();
    stim = '{8'h05, 8'h00};
    run_stim(0);
    chk("ovf_err_u2", 32'(err2), 32'd1);
    chk("ovf_err_u12", 32'(err12), 32'd0);
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) begin
        d[8*b +: 8] = 8'(w * 4 + b + 8'h21);
        stim.push_back(8'(w * 4 + b + 8'h21));
      end
      q12.push_back({16'(w), d});
      if (w < 4) q2.push_back({16'(w), d});
    end
    run_stim(0);
    chk("ovf_u2_flush_busy", 32'(busy2), 32'd1);
    flush_chk("ovf");
    chk("ovf_u2_run_busy", 32'(busy2), 32'd0);
    chk("ovf_words_u2", 32'(wl2), 32'd4);
    chk("ovf_words_u12", 32'(wl12), 32'd5);
    chk("ovf_err_u2_held", 32'(err2), 32'd1);
    idle(2);

    // Reset during DATA, with a load_req pulse that must be ignored.
    push_both(16'd0, 32'h4433_2211);
    start();
    stim = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_stim(0);
    load_req = 1'b1;
    send(8'h55);
    send(8'h66);
    load_req = 1'b0;
    chk("mid_busy_still_loading", 32'(busy12), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_cpu_rst", 32'(cpu12), 32'd1);
    chk("mrst_we", 32'(we12), 32'd0);
    chk("mrst_addr", 32'(addr12), 32'd0);
    chk("mrst_wdata", wd12, 32'd0);
    chk("mrst_words", 32'(wl12), 32'd0);
    chk("mrst_err", 32'(err12), 32'd0);
    chk("mrst_busy", 32'(busy12), 32'd0);
    chk("mrst_in_ready", 32'(rdy12), 32'd0);
    rst = 1'b0;
    idle(2);
    push_both(16'd0, 32'hCAFE_F00D);
    start();
    stim = '{8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    run_stim(2);
    flush_chk("reload");
    chk("reload_words", 32'(wl12), 32'd1);
    idle(3);

    chk("q12_drained", 32'(q12.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
